// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding for the bit-serial arithmetic engines
package serial_arith_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full-subtractor cell (x - y - bin)
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor with start/busy/done handshake
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borr,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] d_top;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             bout;
    logic             last;

    full_subtractor u_cell (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .bin (bw),
        .d   (d),
        .bout(bout)
    );

    // Shift form of {d, r_sh[WIDTH-1:1]} that stays legal when WIDTH is 1.
    assign d_top = WIDTH'(d) << (WIDTH - 1);
    assign r_nx  = (r_sh >> 1) | d_top;
    assign last  = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            bw    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            borr  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bw    <= 1'b0;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    r_sh <= r_nx;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    bw   <= bout;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        diff <= r_nx;
                        borr <= bout;
                        // Overflow only when operand signs differ and the result sign departs from the minuend.
                        ovf  <= (a_msb != b_msb) && (d != a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized check of serial_subtractor (WIDTH 8 and 1) against an arithmetic model
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, busy8, done8, borr8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start1, busy1, done1, borr1, ovf1;
    logic [0:0] a1, b1, diff1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borr(borr8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borr(borr1), .ovf(ovf1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from signed/unsigned integer arithmetic on the operand values.
    function automatic void ref_sub(input int unsigned a, input int unsigned b, input int w,
                                    output logic [63:0] d, output logic br, output logic ov);
        longint m, sa, sb, sd, half;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (longint'(a) >= half) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = (longint'(b) >= half) ? longint'(b) - (longint'(1) << w) : longint'(b);
        sd   = sa - sb;
        d    = 64'((longint'(a) - longint'(b)) & m);
        br   = (a < b);
        ov   = (sd < -half) || (sd > half - 1);
    endfunction

    // Timeline model: p counts cycles since the accepted start (0 = idle).
    int          p8 = 0, p1 = 0;
    int unsigned oa8, ob8, oa1, ob1;
    logic [63:0] e8d = '0, e1d = '0;
    logic        e8b = 1'b0, e8o = 1'b0, e1b = 1'b0, e1o = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            p8 = 0; e8d = '0; e8b = 1'b0; e8o = 1'b0;
            p1 = 0; e1d = '0; e1b = 1'b0; e1o = 1'b0;
        end else begin
            if (p8 == 0) begin
                if (start8) begin oa8 = a8; ob8 = b8; p8 = 1; end
            end else if (p8 == 8) begin
                ref_sub(oa8, ob8, 8, e8d, e8b, e8o); p8 = 9;
            end else if (p8 == 9) begin
                p8 = 0;
            end else begin
                p8++;
            end
            if (p1 == 0) begin
                if (start1) begin oa1 = a1; ob1 = b1; p1 = 1; end
            end else if (p1 == 1) begin
                ref_sub(oa1, ob1, 1, e1d, e1b, e1o); p1 = 2;
            end else begin
                p1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle8 {busy,done,borr,ovf,diff}", {busy8, done8, borr8, ovf8, diff8},
            {(p8 >= 1 && p8 <= 8), (p8 == 9), e8b, e8o, e8d[7:0]});
        chk("cycle1 {busy,done,borr,ovf,diff}", {busy1, done1, borr1, ovf1, diff1},
            {(p1 == 1), (p1 == 2), e1b, e1o, e1d[0]});
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit noise,
                        output int lat, output int nb);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; lat = 1; nb = 0;
        while (lat < 40) begin
            if (busy8) nb++;
            if (done8) break;
            if (noise) begin
                start8 = 1'($urandom % 2); a8 = 8'($urandom); b8 = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        if (!done8) chk("timeout8", done8, 1);
    endtask

    task automatic run1(input logic a, input logic b, output int lat);
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; lat = 1;
        while (lat < 20 && !done1) begin
            @(negedge clk);
            lat++;
        end
        if (!done1) chk("timeout1", done1, 1);
    endtask

    logic [63:0] md;
    logic        mb, mo;
    int          lat, nb, dones;
    logic [7:0]  va [4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
    logic [7:0]  vb [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
    logic [9:0]  vr [4] = '{{8'h02, 2'b00}, {8'hFE, 2'b10}, {8'h7F, 2'b01}, {8'h80, 2'b11}};
    logic [2:0]  w1 [4] = '{3'b000, 3'b111, 3'b100, 3'b000};

    initial begin
        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk("reset8", {busy8, done8, borr8, ovf8, diff8}, 0);
        chk("reset1", {busy1, done1, borr1, ovf1, diff1}, 0);
        rst = 1'b0;

        ref_sub(32'h80, 32'h01, 8, md, mb, mo);
        chk("model 80-01", {md[7:0], mb, mo}, {8'h7F, 2'b01});
        ref_sub(32'h7F, 32'hFF, 8, md, mb, mo);
        chk("model 7F-FF", {md[7:0], mb, mo}, {8'h80, 2'b11});
        ref_sub(32'h0, 32'h1, 1, md, mb, mo);
        chk("model w1 0-1", {md[0], mb, mo}, 3'b111);

        for (int i = 0; i < 4; i++) begin
            run8(va[i], vb[i], (i == 3), lat, nb);
            chk($sformatf("lat8 vec%0d", i), lat, 9);
            chk($sformatf("busy8 cycles vec%0d", i), nb, 8);
            chk($sformatf("result8 vec%0d", i), {diff8, borr8, ovf8}, vr[i]);
        end

        // Abort in the 4th SHIFT cycle; no done may follow.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy before abort", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort8", {busy8, done8, borr8, ovf8, diff8}, 0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dones++;
        end
        chk("no done after abort", dones, 0);
        run8(8'h10, 8'h01, 1'b0, lat, nb);
        chk("post-abort lat8", lat, 9);
        chk("post-abort result8", {diff8, borr8, ovf8}, {8'h0F, 2'b00});

        for (int i = 0; i < 4; i++) begin
            run1(1'(i >> 1), 1'(i), lat);
            chk($sformatf("lat1 ab=%0d", i), lat, 2);
            chk($sformatf("result1 ab=%0d", i), {diff1, borr1, ovf1}, w1[i]);
        end

        fork
            begin
                repeat (120) begin
                    int l, n;
                    run8(8'($urandom), 8'($urandom), 1'($urandom % 2), l, n);
                    chk("rand lat8", l, 9);
                    repeat ($urandom % 3) @(negedge clk);
                end
            end
            begin
                repeat (80) begin
                    int l;
                    run1(1'($urandom), 1'($urandom), l);
                    chk("rand lat1", l, 2);
                    repeat ($urandom % 3) @(negedge clk);
                end
            end
        join

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
